// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Pong game sequencer: serve delay, scoring, point freeze, win.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_SERVE_WAIT = 3'd1;
    localparam logic [2:0] c_PLAY       = 3'd2;
    localparam logic [2:0] c_POINT      = 3'd3;
    localparam logic [2:0] c_GAME_OVER  = 3'd4;

    localparam int c_CNT_MAX = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SERVE_CNT = c_CNT_W'(SERVE_DELAY);
    localparam logic [c_CNT_W-1:0] c_POINT_CNT = c_CNT_W'(POINT_DELAY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_WIN       = 4'(WIN_SCORE);

    logic               r_start_meta, r_start_sync, r_start_prev;
    logic               r_start_vld, r_start_armed, r_start_evt;
    logic               r_vsync, r_vsync_d;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_score1, r_score2;
    logic               r_serve_dir, r_winner;

    logic               w_start_edge, w_frame_tick;
    logic [2:0]         w_state;
    logic [c_CNT_W-1:0] w_cnt, w_cnt_inc;
    logic [3:0]         w_score1, w_score2, w_s1_inc, w_s2_inc;
    logic               w_serve_dir, w_winner;

    // The edge detector is armed only after a genuine low has been seen
    // post-reset, so a switch held high through reset cannot start a game.
    assign w_start_edge = r_start_sync & ~r_start_prev & r_start_armed;
    assign w_frame_tick = r_vsync & ~r_vsync_d;
    assign w_cnt_inc    = r_cnt + c_CNT_ONE;
    assign w_s1_inc     = r_score1 + 4'd1;
    assign w_s2_inc     = r_score2 + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_meta  <= 1'b0;
            r_start_sync  <= 1'b0;
            r_start_prev  <= 1'b0;
            r_start_vld   <= 1'b0;
            r_start_armed <= 1'b0;
            r_start_evt   <= 1'b0;
            r_vsync       <= 1'b0;
            r_vsync_d     <= 1'b0;
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_score1      <= 4'd0;
            r_score2      <= 4'd0;
            r_serve_dir   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_start_meta  <= start;
            r_start_sync  <= r_start_meta;
            r_start_prev  <= r_start_sync;
            r_start_vld   <= 1'b1;
            r_start_armed <= r_start_armed | (r_start_vld & ~r_start_meta);
            r_start_evt   <= w_start_edge;
            r_vsync       <= vsync;
            r_vsync_d     <= r_vsync;
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_score1      <= w_score1;
            r_score2      <= w_score2;
            r_serve_dir   <= w_serve_dir;
            r_winner      <= w_winner;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_score1    = r_score1;
        w_score2    = r_score2;
        w_serve_dir = r_serve_dir;
        w_winner    = r_winner;
        case (r_state)
            c_IDLE: begin
                if (r_start_evt) begin
                    w_score1 = 4'd0;
                    w_score2 = 4'd0;
                    w_cnt    = '0;
                    w_state  = c_SERVE_WAIT;
                end
            end
            c_SERVE_WAIT: begin
                if (w_frame_tick) begin
                    if (w_cnt_inc == c_SERVE_CNT) begin
                        w_cnt   = '0;
                        w_state = c_PLAY;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end
            c_PLAY: begin
                if (miss_left && miss_right) begin
                    w_cnt   = '0;
                    w_state = c_SERVE_WAIT;
                end else if (miss_left) begin
                    w_score2    = w_s2_inc;
                    w_serve_dir = 1'b0;
                    w_cnt       = '0;
                    if (w_s2_inc == c_WIN) begin
                        w_winner = 1'b1;
                        w_state  = c_GAME_OVER;
                    end else begin
                        w_state = c_POINT;
                    end
                end else if (miss_right) begin
                    w_score1    = w_s1_inc;
                    w_serve_dir = 1'b1;
                    w_cnt       = '0;
                    if (w_s1_inc == c_WIN) begin
                        w_winner = 1'b0;
                        w_state  = c_GAME_OVER;
                    end else begin
                        w_state = c_POINT;
                    end
                end
            end
            c_POINT: begin
                if (w_frame_tick) begin
                    if (w_cnt_inc == c_POINT_CNT) begin
                        w_cnt   = '0;
                        w_state = c_SERVE_WAIT;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end
            c_GAME_OVER: begin
                if (r_start_evt) begin
                    w_score1 = 4'd0;
                    w_score2 = 4'd0;
                    w_winner = 1'b0;
                    w_cnt    = '0;
                    w_state  = c_SERVE_WAIT;
                end
            end
            default: begin
                w_cnt   = '0;
                w_state = c_IDLE;
            end
        endcase
    end

    assign ball_enable = (r_state == c_PLAY);
    assign ball_reset  = (r_state == c_IDLE) || (r_state == c_SERVE_WAIT) ||
                         (r_state == c_GAME_OVER);
    assign game_over   = (r_state == c_GAME_OVER);
    assign serve_dir   = r_serve_dir;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Self-checking bench for pong_game_ctrl (WIN=3, SERVE=2, POINT=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int c_WIN = 3;
    localparam int c_SD  = 2;
    localparam int c_PD  = 1;
    localparam int c_HIST = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_enable, ball_reset, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    pong_game_ctrl #(.WIN_SCORE(c_WIN), .SERVE_DELAY(c_SD), .POINT_DELAY(c_PD)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .miss_left(miss_left), .miss_right(miss_right),
        .ball_enable(ball_enable), .ball_reset(ball_reset), .serve_dir(serve_dir),
        .score1(score1), .score2(score2), .game_over(game_over), .winner(winner),
        .state(state)
    );

    always #5 clk = ~clk;

    // Model: input history per edge; start acts 3 edges after its first high
    // sample, a frame tick acts 1 edge after vsync's first high sample.
    bit st_h [c_HIST];
    bit vs_h [c_HIST];
    int cyc = 0;
    int last_rst = 0;
    bit chk_en = 1'b0;
    int m_phase = 0, m_rem = 0, m_s1 = 0, m_s2 = 0;
    bit m_dir = 1'b0, m_win = 1'b0;

    always @(posedge clk) begin : mdl
        int n, ph, rem, s1, s2;
        bit evt, tk, dir, win;
        n = cyc;
        ph = m_phase; rem = m_rem; s1 = m_s1; s2 = m_s2; dir = m_dir; win = m_win;
        if (n < c_HIST) begin
            st_h[n] <= start;
            vs_h[n] <= vsync;
        end
        cyc <= cyc + 1;
        if (reset) begin
            last_rst <= n;
            chk_en   <= 1'b1;
            ph = 0; rem = 0; s1 = 0; s2 = 0; dir = 1'b0; win = 1'b0;
        end else if (n >= 5 && n < c_HIST) begin
            evt = (n - 4 > last_rst) && st_h[n-3] && !st_h[n-4];
            tk  = (n - 1 > last_rst) && vs_h[n-1] && !((n - 2 > last_rst) && vs_h[n-2]);
            if (ph == 0) begin
                if (evt) begin ph = 1; rem = c_SD; s1 = 0; s2 = 0; end
            end else if (ph == 1) begin
                if (tk) begin rem = rem - 1; if (rem == 0) ph = 2; end
            end else if (ph == 2) begin
                if (miss_left && miss_right) begin
                    ph = 1; rem = c_SD;
                end else if (miss_left) begin
                    s2 = s2 + 1; dir = 1'b0;
                    if (s2 == c_WIN) begin ph = 4; win = 1'b1; end
                    else begin ph = 3; rem = c_PD; end
                end else if (miss_right) begin
                    s1 = s1 + 1; dir = 1'b1;
                    if (s1 == c_WIN) begin ph = 4; win = 1'b0; end
                    else begin ph = 3; rem = c_PD; end
                end
            end else if (ph == 3) begin
                if (tk) begin rem = rem - 1; if (rem == 0) begin ph = 1; rem = c_SD; end end
            end else begin
                if (evt) begin ph = 1; rem = c_SD; s1 = 0; s2 = 0; win = 1'b0; end
            end
        end
        m_phase <= ph; m_rem <= rem; m_s1 <= s1; m_s2 <= s2; m_dir <= dir; m_win <= win;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        logic [15:0] act, exp;
        if (chk_en) begin
            act = {state, score1, score2, serve_dir, winner, game_over, ball_enable, ball_reset};
            exp = {m_phase[2:0], m_s1[3:0], m_s2[3:0], m_dir, m_win, (m_phase == 4),
                   (m_phase == 2), (m_phase == 0 || m_phase == 1 || m_phase == 4)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d {state,s1,s2,dir,win,go,en,rst} got=%h want=%h",
                         cyc, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input bit l, input bit r);
        miss_left = l; miss_right = r;
        @(negedge clk);
        miss_left = 1'b0; miss_right = 1'b0;
    endtask

    task automatic toggle_start();
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_ball_reset", ball_reset, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Start latency: first high sample at edge N, state changes at N+3.
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_n2_idle", state, 0);
        @(negedge clk);
        chk("start_n3_serve", state, 1);
        pulse(1'b1, 1'b0);
        chk("miss_ignored_serve", score2, 0);
        frame();
        chk("serve_after_1tick", state, 1);
        frame();
        chk("play_state", state, 2);
        chk("play_enable", ball_enable, 1);

        pulse(1'b0, 1'b1);
        chk("mr_score1", score1, 1);
        chk("mr_dir", serve_dir, 1);
        chk("mr_point", state, 3);
        frame();
        chk("point_to_serve", state, 1);
        frame(); frame();

        pulse(1'b1, 1'b1);
        chk("both_state", state, 1);
        chk("both_s1", score1, 1);
        chk("both_s2", score2, 0);
        frame(); frame();

        for (int k = 0; k < 3; k++) begin
            pulse(1'b1, 1'b0);
            if (k < 2) begin
                frame(); frame(); frame();
            end
        end
        chk("win_s2", score2, 3);
        chk("win_state", state, 4);
        chk("win_winner", winner, 1);
        chk("win_game_over", game_over, 1);
        pulse(1'b1, 1'b0);
        chk("win_hold_s2", score2, 3);

        toggle_start();
        chk("restart_state", state, 1);
        chk("restart_s2", score2, 0);
        chk("restart_go", game_over, 0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_start_idle", state, 0);
        toggle_start();
        chk("retoggle_serve", state, 1);

        frame(); frame();
        pulse(1'b0, 1'b1);
        frame(); frame(); frame();
        pulse(1'b0, 1'b1);
        chk("pre_reset_s1", score1, 2);
        chk("pre_reset_point", state, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("point_reset_state", state, 0);
        chk("point_reset_s1", score1, 0);
        chk("point_reset_ball_reset", ball_reset, 1);

        toggle_start();
        frame(); frame();
        chk("play_again", state, 2);
        reset = 1'b1; miss_left = 1'b1;
        @(negedge clk);
        reset = 1'b0; miss_left = 1'b0;
        chk("reset_miss_s2", score2, 0);
        chk("reset_miss_state", state, 0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9; points needed to win (legal range 1..15).
REQ-002 SHALL have parameter SERVE_DELAY, default 60; frames the ball is held at centre before launch (legal range ≥1).
REQ-003 SHALL have parameter POINT_DELAY, default 30; frames the ball is frozen after a point (legal range ≥1).
REQ-004 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-006 SHALL have port vsync, input, 1 bit; vertical sync from the sync generator, used as the frame reference.
REQ-007 SHALL have port start, input, 1 bit; asynchronous level from the input switch, used to start or restart a game.
REQ-008 SHALL have port miss_left, input, 1 bit; one-cycle pulse, ball passed player-1 edge.
REQ-009 SHALL have port miss_right, input, 1 bit; one-cycle pulse, ball passed player-2 edge.
REQ-010 SHALL have port ball_enable, output, 1 bit; ball datapath may move.
REQ-011 SHALL have port ball_reset, output, 1 bit; ball datapath forced to centre.
REQ-012 SHALL have port serve_dir, output, 1 bit; launch direction, 0 = toward player 1, 1 = toward player 2.
REQ-013 SHALL have ports score1 and score2, output, 4 bits each; player scores.
REQ-014 SHALL have port game_over, output, 1 bit; a game has been won.
REQ-015 SHALL have port winner, output, 1 bit; 0 = player 1, 1 = player 2, valid while game_over = 1.
REQ-016 SHALL have port state, output, 3 bits; current FSM state encoding for debug.

Function
REQ-017 SHALL pass start through a 2-flop synchroniser followed by a rising-edge detector (start_evt); start high before reset release SHALL NOT generate start_evt until it goes low and high again.
REQ-018 SHALL register vsync and generate frame_tick for one cycle on each 0->1 transition of vsync.
REQ-019 SHALL implement states IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4; all outputs decoded from registered state, registered scores and registered flags.
REQ-020 IDLE: ball_reset=1, ball_enable=0; on start_evt, clear scores, clear the frame counter and go to SERVE_WAIT.
REQ-021 SERVE_WAIT: ball_reset=1, ball_enable=0; frame counter increments on frame_tick; the frame_tick that brings the count to SERVE_DELAY SHALL move the FSM to PLAY and clear the counter.
REQ-022 PLAY: ball_enable=1, ball_reset=0.
- miss_left alone: score2+1, serve_dir<=0.
- miss_right alone: score1+1, serve_dir<=1.
- Both in the same cycle: no score change, serve_dir unchanged, go to SERVE_WAIT.
REQ-023 After a score in PLAY, if the new score equals WIN_SCORE, go to GAME_OVER and set winner (1 if score2 won); otherwise go to POINT. The decision SHALL use the incremented value in the same cycle.
REQ-024 POINT: ball_enable=0, ball_reset=0 (ball frozen in place); after POINT_DELAY frame_ticks, go to SERVE_WAIT with the counter cleared.
REQ-025 GAME_OVER: game_over=1, ball_reset=1, ball_enable=0; scores held; on start_evt, clear scores, clear winner and go to SERVE_WAIT.
REQ-026 miss_left and miss_right SHALL be ignored in every state except PLAY.
REQ-027 start_evt SHALL be ignored in SERVE_WAIT, PLAY and POINT.
REQ-028 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-029 A frame_tick in the same cycle as a state entry SHALL count toward the new state's delay only if it arrives on a later cycle.
REQ-030 Latency: a start 0->1 change sampled on clock edge N SHALL change the state on edge N+3.

Reset
REQ-031 On a clk edge with reset=1, from any state:
- state=IDLE, score1=score2=0, serve_dir=0, winner=0, game_over=0, ball_enable=0, ball_reset=1;
- counter, synchroniser and vsync/start edge registers cleared.
REQ-032 Reset asserted mid-PLAY SHALL discard a coincident miss pulse.

Verification (WIN_SCORE=3, SERVE_DELAY=2, POINT_DELAY=1)
REQ-033 Reset, then raise start -> state IDLE to SERVE_WAIT on the 3rd edge; PLAY on the 2nd frame_tick; ball_enable=1.
REQ-034 In PLAY, pulse miss_right -> score1=1, serve_dir=1, state POINT; after 1 frame_tick -> SERVE_WAIT.
REQ-035 In PLAY, pulse miss_left and miss_right together -> scores unchanged, state SERVE_WAIT.
REQ-036 Three miss_left points -> score2=3, GAME_OVER, winner=1, game_over=1; a further miss_left leaves score2 at 3.
REQ-037 In GAME_OVER, toggle start -> scores 0, game_over=0, SERVE_WAIT; hold start high through reset -> stays IDLE until start is re-toggled.
REQ-038 Assert reset during POINT with score1=2 -> next edge: IDLE, scores 0, ball_reset=1.
